trax_move_sequencer: RTL

- Central controller for one Trax turn.
- Takes the opponent move from the transceiver and sequences the board datapath phase engines through start/done handshakes: apply+auto-complete, commit copy to map, shift down, shift right, candidate generation.
- Then applies its own chosen move the same way and fires the transmit request.
- Sits between the transceiver and the board/move-generation datapath. It replaces ad-hoc step counters with one explicit FSM.

---
 rtl/trax_pkg.sv | 54 +++++
 rtl/trax_phase_watchdog.sv | 36 +++
 rtl/trax_move_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/trax_pkg.sv
// Shared Trax types: tile codes, colours, move-word layout, phase indices and
// sequencer states used by the move sequencer and the board datapath.
package trax_pkg;

    localparam int MOVE_W   = 22;
    localparam int ROW_LSB  = 0;
    localparam int COL_LSB  = 10;
    localparam int TILE_LSB = 20;
    localparam int N_PHASES = 5;

    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'd0,
        TILE_PLUS   = 2'd1,
        TILE_SLASH  = 2'd2,
        TILE_BSLASH = 2'd3
    } tile_e;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } color_e;

    // Bit positions inside phase_start / phase_done.
    typedef enum logic [2:0] {
        PH_APPLY   = 3'd0,
        PH_COMMIT  = 3'd1,
        PH_SHIFT_D = 3'd2,
        PH_SHIFT_R = 3'd3,
        PH_GEN     = 3'd4
    } phase_e;

    typedef enum logic {
        PASS_OPP = 1'b0,
        PASS_OWN = 1'b1
    } pass_e;

    typedef enum logic [3:0] {
        S_WAIT_COLOR,
        S_IDLE,
        S_APPLY,
        S_COMMIT,
        S_SHIFT_D,
        S_SHIFT_R,
        S_NEXT,
        S_GEN,
        S_SEND,
        S_ERR
    } seq_state_e;

    function automatic logic [MOVE_W-1:0] make_move(tile_e tile, logic [9:0] col, logic [9:0] row);
        return {tile, col, row};
    endfunction

endpackage

// File: rtl/trax_phase_watchdog.sv
// Per-phase busy watchdog: cleared on every phase start, counts while a phase
// is outstanding and flags a timeout once the limit is reached.
module trax_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam logic [11:0] LIMIT = 12'(TIMEOUT_CYCLES);

    logic [11:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/trax_move_sequencer.sv
// One-turn Trax controller: applies the opponent move, generates and applies our
// reply through the phase engines, then requests transmit. TRAX_SEQ_WATCHDOG_EN adds a phase watchdog.
module trax_move_sequencer
    import trax_pkg::*;
#(
    parameter int MOVE_W         = trax_pkg::MOVE_W,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [MOVE_W-1:0] rx_move,
    input  logic              my_color,
    output logic [4:0]        phase_start,
    input  logic [4:0]        phase_done,
    input  logic              need_shift_down,
    input  logic              need_shift_right,
    input  logic [MOVE_W-1:0] cand_move,
    output logic [MOVE_W-1:0] work_move,
    output logic              tx_start,
    output logic [MOVE_W-1:0] tx_move,
    output logic              busy,
    output logic              overrun,
    output logic              err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4095) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 12-bit phase watchdog");
    end

    seq_state_e        state_q, state_d;
    pass_e             pass_q, pass_d;
    logic [MOVE_W-1:0] work_move_q, work_move_d;
    logic [MOVE_W-1:0] tx_move_q, tx_move_d;
    logic [4:0]        phase_start_q, phase_start_d;
    logic              tx_start_q, tx_start_d;
    logic              shr_q, shr_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              err_q, err_d;
    logic              waiting;
    logic              timeout;

    // A done pulse in the same cycle as its start is not a real completion.
    assign waiting = (phase_start_q == '0);

`ifdef TRAX_SEQ_WATCHDOG_EN
    logic in_phase;
    assign in_phase = state_q inside {S_APPLY, S_COMMIT, S_SHIFT_D, S_SHIFT_R, S_GEN};

    trax_phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (|phase_start_q),
        .count_en(in_phase),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        pass_d        = pass_q;
        work_move_d   = work_move_q;
        tx_move_d     = tx_move_q;
        shr_d         = shr_q;
        phase_start_d = '0;
        tx_start_d    = 1'b0;
        overrun_d     = overrun_q | (rx_valid & busy_q);
        err_d         = err_q;

        unique case (state_q)
            S_WAIT_COLOR: if (rx_valid) begin
                if (my_color == WHITE) begin
                    work_move_d             = make_move(TILE_PLUS, 10'd0, 10'd0);
                    pass_d                  = PASS_OWN;
                    state_d                 = S_APPLY;
                    phase_start_d[PH_APPLY] = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: if (rx_valid) begin
                work_move_d             = rx_move;
                pass_d                  = PASS_OPP;
                state_d                 = S_APPLY;
                phase_start_d[PH_APPLY] = 1'b1;
            end
            S_APPLY: if (waiting && phase_done[PH_APPLY]) begin
                state_d                  = S_COMMIT;
                phase_start_d[PH_COMMIT] = 1'b1;
            end
            S_COMMIT: if (waiting && phase_done[PH_COMMIT]) begin
                shr_d = need_shift_right;
                if (need_shift_down) begin
                    state_d                   = S_SHIFT_D;
                    phase_start_d[PH_SHIFT_D] = 1'b1;
                end else if (need_shift_right) begin
                    state_d                   = S_SHIFT_R;
                    phase_start_d[PH_SHIFT_R] = 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_SHIFT_D: if (waiting && phase_done[PH_SHIFT_D]) begin
                if (shr_q) begin
                    state_d                   = S_SHIFT_R;
                    phase_start_d[PH_SHIFT_R] = 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_SHIFT_R: if (waiting && phase_done[PH_SHIFT_R]) begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (pass_q == PASS_OPP) begin
                    state_d               = S_GEN;
                    phase_start_d[PH_GEN] = 1'b1;
                end else begin
                    state_d    = S_SEND;
                    tx_start_d = 1'b1;
                    tx_move_d  = work_move_q;
                end
            end
            S_GEN: if (waiting && phase_done[PH_GEN]) begin
                if (cand_move == '0) begin
                    state_d    = S_SEND;
                    tx_start_d = 1'b1;
                    tx_move_d  = '0;
                end else begin
                    work_move_d             = cand_move;
                    pass_d                  = PASS_OWN;
                    state_d                 = S_APPLY;
                    phase_start_d[PH_APPLY] = 1'b1;
                end
            end
            S_SEND:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_WAIT_COLOR;
        endcase

        if (timeout) begin
            state_d       = S_ERR;
            err_d         = 1'b1;
            phase_start_d = '0;
            tx_start_d    = 1'b0;
        end

        busy_d = !(state_d inside {S_IDLE, S_WAIT_COLOR});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_WAIT_COLOR;
            pass_q        <= PASS_OPP;
            work_move_q   <= '0;
            tx_move_q     <= '0;
            phase_start_q <= '0;
            tx_start_q    <= 1'b0;
            shr_q         <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q       <= state_d;
            pass_q        <= pass_d;
            work_move_q   <= work_move_d;
            tx_move_q     <= tx_move_d;
            phase_start_q <= phase_start_d;
            tx_start_q    <= tx_start_d;
            shr_q         <= shr_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            err_q         <= err_d;
        end
    end

    assign phase_start = phase_start_q;
    assign work_move   = work_move_q;
    assign tx_start    = tx_start_q;
    assign tx_move     = tx_move_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign err         = err_q;

endmodule
